uart_rx_core: RTL

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// UART receive core: synchronizes the serial line, samples frames at mid-bit,
// and presents the last byte plus sticky pending/frame-error/overrun flags.
module uart_rx_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        uart_clk,
  input  logic        sys_rstn,
  input  logic        uart_en,
  input  logic [15:0] uart_baud,
  input  logic        uart_prty_en,
  input  logic        uart_rx,
  input  logic        uart_rxpnd_clr,
  output logic [7:0]  rxbuf,
  output logic        rx_bit9,
  output logic        uart_rxpnd,
  output logic        uart_ferr,
  output logic        uart_ovf,
  output logic        rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PRTY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            bit_cnt_q, bit_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   bit9_q, bit9_d;
  logic                   prty_q, prty_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   settle_q;
  logic                   rx_prev_q;
  logic                   rx_s;
  logic                   start_det;
  logic                   sample;
  logic                   done;
  logic [15:0]            baud_eff;
  logic [15:0]            half_baud;

  assign rx_s = sync_q[SYNC_STAGES-1];
  // The reset value of the synchronizer looks like a high line; settle_q holds
  // off edge detection until real line samples have reached rx_prev_q.
  assign start_det = rx_prev_q & ~rx_s & settle_q[SYNC_STAGES];
  assign baud_eff  = (uart_baud < 16'd3) ? 16'd3 : uart_baud;
  assign half_baud = {1'b0, baud_eff[15:1]};
  assign sample    = (bit_cnt_q == baud_eff);

  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync_q    <= '1;
      settle_q  <= '0;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      settle_q  <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q   <= IDLE;
      bit_cnt_q <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      bit9_q    <= 1'b0;
      prty_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      bit9_q    <= bit9_d;
      prty_q    <= prty_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    bit9_d    = bit9_q;
    prty_d    = prty_q;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = 16'd0;
        if (start_det && uart_en) state_d = START;
      end
      START: begin
        if (bit_cnt_q == half_baud) begin
          bit_cnt_d = 16'd0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
            prty_d    = uart_prty_en;
            bit9_d    = 1'b0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      DATA, PRTY, STOP: begin
        bit_cnt_d = sample ? 16'd0 : bit_cnt_q + 16'd1;
        if (sample) begin
          case (state_q)
            DATA: begin
              shift_d   = {rx_s, shift_q[7:1]};
              bit_idx_d = bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) state_d = prty_q ? PRTY : STOP;
            end
            PRTY: begin
              bit9_d  = rx_s;
              state_d = STOP;
            end
            default: begin
              state_d = IDLE;
              done    = 1'b1;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
    if (!uart_en) begin
      state_d   = IDLE;
      bit_cnt_d = 16'd0;
      bit_idx_d = 3'd0;
      done      = 1'b0;
    end
  end

  always_comb begin
    rx_busy = (state_q != IDLE);
  end

  // A completion in the same cycle as a clear request keeps every flag it sets.
  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rxbuf      <= 8'd0;
      rx_bit9    <= 1'b0;
      uart_rxpnd <= 1'b0;
      uart_ferr  <= 1'b0;
      uart_ovf   <= 1'b0;
    end else if (done) begin
      rxbuf      <= shift_q;
      rx_bit9    <= bit9_q;
      uart_rxpnd <= 1'b1;
      uart_ferr  <= (uart_ferr & ~uart_rxpnd_clr) | ~rx_s;
      uart_ovf   <= (uart_ovf & ~uart_rxpnd_clr) | uart_rxpnd;
    end else if (uart_rxpnd_clr) begin
      uart_rxpnd <= 1'b0;
      uart_ferr  <= 1'b0;
      uart_ovf   <= 1'b0;
    end
  end

endmodule
